vproc_issue_ctrl: RTL and testbench
===================================

# vproc_issue_ctrl

In-order issue controller between the CVA6 issue stage and the vector-coprocessor wrapper. It buffers offloaded vector instructions and their scalar operands in a small FIFO, and presents them one at a time on the wrapper's valid/ready handshake. It caps the number of in-flight instructions, forwards completions to scalar writeback, and on a pipeline flush drops queued entries and suppresses results of entries already handed to the wrapper.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- MAX_OUTSTANDING, 2, max instructions accepted by wrapper without returned result; 1..15

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- flush_i  in  1  pipeline flush, single-cycle pulse
- issue_valid_i  in  1  instruction offered by issue stage
- issue_ready_o  out  1  controller can accept
- issue_trans_id_i  in  TRANS_ID_BITS  scoreboard transaction ID
- issue_instr_i  in  32  vector instruction word
- issue_rs1_i, issue_rs2_i  in  riscv::XLEN  scalar operands
- vect_instr_valid_o  out  1  head entry offered to wrapper
- vect_ready_i  in  1  wrapper accepts
- vect_trans_id_o  out  TRANS_ID_BITS  head trans ID
- vect_instr_o  out  32  head instruction
- vect_rs1_o, vect_rs2_o  out  riscv::XLEN  head operands
- vect_valid_i  in  1  wrapper completion
- vect_trans_id_i  in  TRANS_ID_BITS  completion trans ID
- vect_result_i  in  riscv::XLEN  completion result
- wb_valid_o  out  1  result to writeback
- wb_trans_id_o  out  TRANS_ID_BITS  writeback trans ID
- wb_result_o  out  riscv::XLEN  writeback data
- busy_o  out  1  FIFO non-empty or outstanding ≠ 0
- perf_stall_o  out  32  stall-cycle count (see Configuration)

## Operation
- State: FIFO (count 0..DEPTH, rd/wr pointers wrapping modulo DEPTH), outstanding counter (0..MAX_OUTSTANDING), kill counter (0..MAX_OUTSTANDING).
- Push: issue_valid_i & issue_ready_o writes entry at wr pointer. issue_ready_o = (count < DEPTH) & ~flush_i; independent of same-cycle pop.
- Pop: vect_instr_valid_o = (count ≠ 0) & (outstanding < MAX_OUTSTANDING) & ~flush_i; payload outputs always show the head entry. A pop occurs on vect_instr_valid_o & vect_ready_i; outstanding +1.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Completion: vect_valid_i decrements outstanding. If kill counter = 0 and ~flush_i, the completion passes combinationally: wb_valid_o = 1, wb_trans_id_o = vect_trans_id_i, wb_result_o = vect_result_i. Otherwise wb_valid_o = 0 and kill counter −1 when nonzero.
- Flush: count and both pointers reset to 0. Kill counter loads outstanding_next, the outstanding value after this cycle's completion; no pop occurs in the flush cycle. Outstanding is not cleared, because the wrapper still returns those results.
- Completion with outstanding = 0 is a protocol error. Counters saturate at 0, wb_valid_o = 0, simulation assertion fires.
- Reset mid-operation clears all state; in-flight wrapper instructions are discarded because the wrapper shares rst_ni.
- Reset values: issue_ready_o 1, vect_instr_valid_o 0, vect payload 0, wb_valid_o 0, busy_o 0, perf_stall_o 0.

## Timing
- Issue to vect_instr_valid_o: 1 cycle minimum; the FIFO is registered, with no fall-through.
- Completion to writeback: 0 cycles, combinational.
- Throughput: 1 push and 1 pop per cycle.
- issue_ready_o rises the cycle after a pop from a full FIFO.
- Once asserted, vect_instr_valid_o holds with stable payload until accepted or flushed.
- issue_ready_o, vect_instr_valid_o and wb_valid_o depend combinationally on flush_i. No combinational path from vect_ready_i to issue_ready_o.

## Configuration
- VPROC_ISSUE_PERF_EN defined: perf_stall_o is a 32-bit wrapping counter, incremented each cycle where count ≠ 0 and no pop occurs. It is cleared by reset only.
- Not defined: perf_stall_o tied to 0 and no counter flops; the port list is unchanged.

## Structure
- Package vproc_issue_pkg holds:
  - typedef vproc_issue_entry_t: trans_id, instr, rs1, rs2
  - localparams for pointer and counter widths: $clog2(DEPTH), $clog2(MAX_OUTSTANDING+1)
- Sub-module vproc_issue_fifo: parameterised synchronous FIFO of vproc_issue_entry_t with push, pop, clear, count, head.

## Test plan
- Reset, then push 3 entries (IDs 1,2,3) with vect_ready_i=1 -> vect_instr_valid_o first high cycle 2, IDs popped in order 1,2,3.
- MAX_OUTSTANDING=2, no completions, push 4 -> exactly 2 pops, then vect_instr_valid_o=0. One completion -> third pops the next cycle.
- vect_ready_i=0, push 4 -> issue_ready_o=0 at count 4, perf_stall_o increments per cycle with PERF_EN and stays 0 without. Then ready=1 -> issue_ready_o back to 1 the cycle after the first pop.
- Completion ID 5, result 0xDEADBEEF, kill=0 -> wb_valid_o=1 same cycle, wb_trans_id_o=5, wb_result_o=0xDEADBEEF.
- 2 outstanding, 2 queued, flush_i pulse -> count 0, kill=2, next 2 completions give wb_valid_o=0, third completion written back.
- Flush in the same cycle as a completion with outstanding=1 -> wb_valid_o=0, kill=0, outstanding=0, busy_o=0 next cycle.

Source files
------------

// File: rtl/vproc_issue_pkg.sv
// vproc_issue_pkg: shared widths and the queued-instruction record for the vector issue controller.
package vproc_issue_pkg;
  localparam int XLEN = 64;
  localparam int TRANS_ID_BITS = 4;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_MAX_OUT = 2;
  localparam int PTR_W = $clog2(DEFAULT_DEPTH);
  localparam int OUT_W = $clog2(DEFAULT_MAX_OUT + 1);
  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [31:0] instr;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
  } vproc_issue_entry_t;
endpackage

// File: rtl/vproc_issue_if.sv
// vproc_issue_if: issue-stage, wrapper and writeback handshakes of the vector issue controller.
interface vproc_issue_if;
  import vproc_issue_pkg::*;
  logic issue_valid_i;
  logic issue_ready_o;
  logic [TRANS_ID_BITS-1:0] issue_trans_id_i;
  logic [31:0] issue_instr_i;
  logic [XLEN-1:0] issue_rs1_i;
  logic [XLEN-1:0] issue_rs2_i;
  logic vect_instr_valid_o;
  logic vect_ready_i;
  logic [TRANS_ID_BITS-1:0] vect_trans_id_o;
  logic [31:0] vect_instr_o;
  logic [XLEN-1:0] vect_rs1_o;
  logic [XLEN-1:0] vect_rs2_o;
  logic vect_valid_i;
  logic [TRANS_ID_BITS-1:0] vect_trans_id_i;
  logic [XLEN-1:0] vect_result_i;
  logic wb_valid_o;
  logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
  logic [XLEN-1:0] wb_result_o;
  modport slave (
    input  issue_valid_i, issue_trans_id_i, issue_instr_i, issue_rs1_i, issue_rs2_i,
    input  vect_ready_i, vect_valid_i, vect_trans_id_i, vect_result_i,
    output issue_ready_o, vect_instr_valid_o, vect_trans_id_o, vect_instr_o, vect_rs1_o, vect_rs2_o,
    output wb_valid_o, wb_trans_id_o, wb_result_o
  );
  modport master (
    output issue_valid_i, issue_trans_id_i, issue_instr_i, issue_rs1_i, issue_rs2_i,
    output vect_ready_i, vect_valid_i, vect_trans_id_i, vect_result_i,
    input  issue_ready_o, vect_instr_valid_o, vect_trans_id_o, vect_instr_o, vect_rs1_o, vect_rs2_o,
    input  wb_valid_o, wb_trans_id_o, wb_result_o
  );
endinterface

// File: rtl/vproc_issue_fifo.sv
// vproc_issue_fifo: registered FIFO of issue entries; head is always the oldest entry, no fall-through.
module vproc_issue_fifo
  import vproc_issue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push,
  input  logic pop,
  input  logic clear,
  input  vproc_issue_entry_t wdata,
  output vproc_issue_entry_t head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [PW-1:0] rd_ptr, wr_ptr;
  vproc_issue_entry_t mem [DEPTH];
  assign head = mem[rd_ptr];
  // storage is reset so the wrapper payload reads zero out of reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) mem[wr_ptr] <= wdata;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/vproc_issue_ctrl.sv
// vproc_issue_ctrl: in-order vector issue controller with in-flight cap and flush kill tracking.
// Define VPROC_ISSUE_PERF_EN to build the stall-cycle counter on perf_stall_o.
module vproc_issue_ctrl
  import vproc_issue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  vproc_issue_if.slave bus,
  output logic busy_o,
  output logic [31:0] perf_stall_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  logic [CW-1:0] count;
  logic [OW-1:0] outstanding, outstanding_next, kill;
  logic push, pop, cpl;
  vproc_issue_entry_t wdata, head;
  assign bus.issue_ready_o = (count < CW'(DEPTH)) & ~flush_i;
  assign bus.vect_instr_valid_o = (count != '0) & (outstanding < OW'(MAX_OUTSTANDING)) & ~flush_i;
  assign push = bus.issue_valid_i & bus.issue_ready_o;
  assign pop = bus.vect_instr_valid_o & bus.vect_ready_i;
  // a completion with nothing outstanding is ignored so the counters saturate at zero
  assign cpl = bus.vect_valid_i & (outstanding != '0);
  assign outstanding_next = outstanding + OW'(pop) - OW'(cpl);
  assign bus.wb_valid_o = cpl & (kill == '0) & ~flush_i;
  assign bus.wb_trans_id_o = bus.vect_trans_id_i;
  assign bus.wb_result_o = bus.vect_result_i;
  assign wdata = '{trans_id: bus.issue_trans_id_i, instr: bus.issue_instr_i,
                   rs1: bus.issue_rs1_i, rs2: bus.issue_rs2_i};
  assign bus.vect_trans_id_o = head.trans_id;
  assign bus.vect_instr_o = head.instr;
  assign bus.vect_rs1_o = head.rs1;
  assign bus.vect_rs2_o = head.rs2;
  assign busy_o = (count != '0) | (outstanding != '0);
  vproc_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .push(push), .pop(pop), .clear(flush_i),
    .wdata(wdata), .head(head), .count(count)
  );
  // on flush every instruction still in the wrapper becomes a result to discard
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= '0;
      kill <= '0;
    end else begin
      outstanding <= outstanding_next;
      kill <= flush_i ? outstanding_next : kill - OW'(bus.vect_valid_i & (kill != '0));
    end
  end
`ifdef VPROC_ISSUE_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perf_stall_o <= '0;
    else if ((count != '0) & ~pop) perf_stall_o <= perf_stall_o + 32'd1;
  end
`else
  assign perf_stall_o = '0;
`endif
  a_no_spurious_cpl: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(bus.vect_valid_i && outstanding == '0));
endmodule

// File: tb/tb_vproc_issue_ctrl.sv
// tb_vproc_issue_ctrl: table-driven directed bench for vproc_issue_ctrl (DEPTH=4, MAX_OUTSTANDING=2).
module tb_vproc_issue_ctrl;
  import vproc_issue_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;
  logic [31:0] perf;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  vproc_issue_if bus();
  vproc_issue_ctrl #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus.slave), .busy_o(busy), .perf_stall_o(perf)
  );
  typedef struct {
    logic fl, iv, vr, cv;
    int id, cid;
    logic [31:0] res;
    logic ir, vv, wv, busy;
    int vid, wid, perf;
    logic [31:0] wres;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mv(logic fl, logic iv, int id, logic vr, logic cv, int cid, logic [31:0] res,
                              logic ir, logic vv, int vid, logic wv, int wid, logic [31:0] wres,
                              logic b, int p);
    vec_t v;
    v = '{fl: fl, iv: iv, vr: vr, cv: cv, id: id, cid: cid, res: res, ir: ir, vv: vv, wv: wv,
          busy: b, vid: vid, wid: wid, perf: p, wres: wres};
    return v;
  endfunction
  function automatic logic [31:0] instr_of(int id);
    return 32'hC0DE_0000 | 32'(id);
  endfunction
  function automatic logic [63:0] rs1_of(int id);
    return 64'h1000 + 64'(id);
  endfunction
  function automatic logic [63:0] rs2_of(int id);
    return 64'hABCD_0000_0000_0000 | 64'(id);
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic drive(logic fl, logic iv, int id, logic vr, logic cv, int cid, logic [63:0] res);
    flush = fl;
    bus.issue_valid_i = iv;
    bus.issue_trans_id_i = TRANS_ID_BITS'(id);
    bus.issue_instr_i = instr_of(id);
    bus.issue_rs1_i = rs1_of(id);
    bus.issue_rs2_i = rs2_of(id);
    bus.vect_ready_i = vr;
    bus.vect_valid_i = cv;
    bus.vect_trans_id_i = TRANS_ID_BITS'(cid);
    bus.vect_result_i = res;
  endtask
  initial begin
    int exp_perf;
    drive(0, 0, 0, 0, 0, 0, 0);
    //           fl iv id vr cv cid res            ir vv vid wv wid wres          busy perf
    tbl.push_back(mv(0, 1, 1, 1, 0, 0, 0,            1, 0, 0, 0, 0, 0,            0, 0));
    tbl.push_back(mv(0, 1, 2, 1, 0, 0, 0,            1, 1, 1, 0, 0, 0,            1, 0));
    tbl.push_back(mv(0, 1, 3, 1, 0, 0, 0,            1, 1, 2, 0, 0, 0,            1, 0));
    tbl.push_back(mv(0, 0, 0, 1, 1, 1, 32'h11,       1, 0, 0, 1, 1, 32'h11,       1, 0));
    tbl.push_back(mv(0, 0, 0, 1, 1, 2, 32'h22,       1, 1, 3, 1, 2, 32'h22,       1, 1));
    tbl.push_back(mv(0, 0, 0, 1, 1, 3, 32'h33,       1, 0, 0, 1, 3, 32'h33,       1, 1));
    tbl.push_back(mv(0, 0, 0, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0,            0, 1));
    tbl.push_back(mv(0, 1, 4, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0,            0, 1));
    tbl.push_back(mv(0, 1, 5, 0, 0, 0, 0,            1, 1, 4, 0, 0, 0,            1, 1));
    tbl.push_back(mv(0, 1, 6, 0, 0, 0, 0,            1, 1, 4, 0, 0, 0,            1, 2));
    tbl.push_back(mv(0, 1, 7, 0, 0, 0, 0,            1, 1, 4, 0, 0, 0,            1, 3));
    tbl.push_back(mv(0, 1, 8, 0, 0, 0, 0,            0, 1, 4, 0, 0, 0,            1, 4));
    tbl.push_back(mv(0, 0, 0, 1, 0, 0, 0,            0, 1, 4, 0, 0, 0,            1, 5));
    tbl.push_back(mv(0, 0, 0, 0, 0, 0, 0,            1, 1, 5, 0, 0, 0,            1, 5));
    tbl.push_back(mv(0, 0, 0, 1, 0, 0, 0,            1, 1, 5, 0, 0, 0,            1, 6));
    tbl.push_back(mv(1, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0,            1, 6));
    tbl.push_back(mv(0, 0, 0, 0, 1, 4, 32'h44,       1, 0, 0, 0, 0, 0,            1, 7));
    tbl.push_back(mv(0, 1, 9, 0, 1, 5, 32'h55,       1, 0, 0, 0, 0, 0,            1, 7));
    tbl.push_back(mv(0, 0, 0, 1, 0, 0, 0,            1, 1, 9, 0, 0, 0,            1, 7));
    tbl.push_back(mv(0, 0, 0, 0, 1, 9, 32'h99,       1, 0, 0, 1, 9, 32'h99,       1, 7));
    tbl.push_back(mv(0, 1, 5, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0,            0, 7));
    tbl.push_back(mv(0, 0, 0, 1, 0, 0, 0,            1, 1, 5, 0, 0, 0,            1, 7));
    tbl.push_back(mv(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 1, 0, 0, 1, 5, 32'hDEADBEEF, 1, 7));
    tbl.push_back(mv(0, 1, 6, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0,            0, 7));
    tbl.push_back(mv(0, 0, 0, 1, 0, 0, 0,            1, 1, 6, 0, 0, 0,            1, 7));
    tbl.push_back(mv(1, 0, 0, 0, 1, 6, 32'h66,       0, 0, 0, 0, 0, 0,            1, 7));
    tbl.push_back(mv(0, 0, 0, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0,            0, 7));
    tbl.push_back(mv(0, 1, 7, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0,            0, 7));
    tbl.push_back(mv(0, 0, 0, 1, 0, 0, 0,            1, 1, 7, 0, 0, 0,            1, 7));
    tbl.push_back(mv(0, 0, 0, 0, 1, 7, 32'h77,       1, 0, 0, 1, 7, 32'h77,       1, 7));
    tbl.push_back(mv(0, 0, 0, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0,            0, 7));
    repeat (2) @(negedge clk);
    chk("rst_issue_ready", 64'(bus.issue_ready_o), 64'd1);
    chk("rst_vect_valid", 64'(bus.vect_instr_valid_o), 64'd0);
    chk("rst_vect_id", 64'(bus.vect_trans_id_o), 64'd0);
    chk("rst_vect_instr", 64'(bus.vect_instr_o), 64'd0);
    chk("rst_vect_rs1", bus.vect_rs1_o, 64'd0);
    chk("rst_vect_rs2", bus.vect_rs2_o, 64'd0);
    chk("rst_wb_valid", 64'(bus.wb_valid_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_perf", 64'(perf), 64'd0);
    rst_n = 1'b1;
    foreach (tbl[n]) begin
      @(negedge clk);
      drive(tbl[n].fl, tbl[n].iv, tbl[n].id, tbl[n].vr, tbl[n].cv, tbl[n].cid, 64'(tbl[n].res));
      #1;
      chk($sformatf("v%0d_issue_ready", n), 64'(bus.issue_ready_o), 64'(tbl[n].ir));
      chk($sformatf("v%0d_vect_valid", n), 64'(bus.vect_instr_valid_o), 64'(tbl[n].vv));
      if (tbl[n].vv) begin
        chk($sformatf("v%0d_vect_id", n), 64'(bus.vect_trans_id_o), 64'(tbl[n].vid));
        chk($sformatf("v%0d_vect_instr", n), 64'(bus.vect_instr_o), 64'(instr_of(tbl[n].vid)));
        chk($sformatf("v%0d_vect_rs1", n), bus.vect_rs1_o, rs1_of(tbl[n].vid));
        chk($sformatf("v%0d_vect_rs2", n), bus.vect_rs2_o, rs2_of(tbl[n].vid));
      end
      chk($sformatf("v%0d_wb_valid", n), 64'(bus.wb_valid_o), 64'(tbl[n].wv));
      if (tbl[n].wv) begin
        chk($sformatf("v%0d_wb_id", n), 64'(bus.wb_trans_id_o), 64'(tbl[n].wid));
        chk($sformatf("v%0d_wb_result", n), bus.wb_result_o, 64'(tbl[n].wres));
      end
      chk($sformatf("v%0d_busy", n), 64'(busy), 64'(tbl[n].busy));
`ifdef VPROC_ISSUE_PERF_EN
      exp_perf = tbl[n].perf;
`else
      exp_perf = 0;
`endif
      chk($sformatf("v%0d_perf", n), 64'(perf), 64'(exp_perf));
    end
    @(negedge clk);
    drive(0, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 1, 2, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pre_rst_vect_valid", 64'(bus.vect_instr_valid_o), 64'd1);
    chk("pre_rst_vect_id", 64'(bus.vect_trans_id_o), 64'd1);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_issue_ready", 64'(bus.issue_ready_o), 64'd1);
    chk("mid_rst_vect_valid", 64'(bus.vect_instr_valid_o), 64'd0);
    chk("mid_rst_vect_instr", 64'(bus.vect_instr_o), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_perf", 64'(perf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_vect_valid", 64'(bus.vect_instr_valid_o), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
